// File: rtl/multicycle_controller.sv
// multicycle_controller
// Multicycle fetch/decode/execute/memory/writeback sequencer. Owns the PC,
// the instruction latch, the registered ALU operands and the writeback mux.
// Memory traffic uses a req/ack handshake with a bounded wait; misaligned
// fetches and bus errors trap into sticky error states.
// Optional feature: define INSTRET_EN to add a 64-bit retired-instruction
// counter on output port instret.

module multicycle_controller #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int              MEM_TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [1:0]      mem_size,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    input  logic            mem_err,
    output logic [XLEN-1:0] instr,
    input  logic            dec_error,
    input  logic            dec_load,
    input  logic [2:0]      dec_load_size,
    input  logic [1:0]      dec_store_size,
    input  logic            dec_reg_write,
    input  logic            dec_jump,
    input  logic            dec_jal,
    input  logic            dec_branch,
    input  logic            branch_taken,
    input  logic            rs1_use_pc,
    input  logic            rs2_use_imm,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] rv1,
    input  logic [XLEN-1:0] rv2,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_out,
    output logic            rf_we,
    output logic [XLEN-1:0] rf_wdata,
    output logic [XLEN-1:0] pc,
    output logic [3:0]      state,
    output logic            halted
`ifdef INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    localparam logic [3:0] S_START        = 4'h0;
    localparam logic [3:0] S_FETCH        = 4'h1;
    localparam logic [3:0] S_WAIT_FETCH   = 4'h2;
    localparam logic [3:0] S_DECODE       = 4'h3;
    localparam logic [3:0] S_EXECUTE      = 4'h4;
    localparam logic [3:0] S_MEM_ACCESS   = 4'h5;
    localparam logic [3:0] S_WAIT_MEM     = 4'h6;
    localparam logic [3:0] S_WRITEBACK    = 4'h7;
    localparam logic [3:0] S_MEM_ERROR    = 4'hD;
    localparam logic [3:0] S_DECODE_ERROR = 4'hE;
    localparam logic [3:0] S_FSM_ERROR    = 4'hF;

    localparam logic [7:0]      TMO_LAST  = 8'(MEM_TIMEOUT - 1);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);
    localparam logic [XLEN-1:0] LSB_CLEAR = {{(XLEN-1){1'b1}}, 1'b0};

    // Memory size code for a load, selected by its funct3.
    function automatic logic [1:0] load_mem_size(input logic [2:0] funct3);
        logic [1:0] size;
        case (funct3)
            3'b000, 3'b100: size = 2'b01;
            3'b001, 3'b101: size = 2'b10;
            default:        size = 2'b11;
        endcase
        return size;
    endfunction

    // Sign/zero extension of right-justified load data by funct3.
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      funct3,
                                                    input logic [XLEN-1:0] data);
        logic [XLEN-1:0] ext;
        case (funct3)
            3'b000:  ext = {{(XLEN-8){data[7]}}, data[7:0]};
            3'b001:  ext = {{(XLEN-16){data[15]}}, data[15:0]};
            3'b100:  ext = {{(XLEN-8){1'b0}}, data[7:0]};
            3'b101:  ext = {{(XLEN-16){1'b0}}, data[15:0]};
            default: ext = data;
        endcase
        return ext;
    endfunction

    logic [3:0]      state_r,     state_s;
    logic            halted_r,    halted_s;
    logic [XLEN-1:0] pc_r,        pc_s;
    logic [XLEN-1:0] instr_r,     instr_s;
    logic [XLEN-1:0] alu_a_r,     alu_a_s;
    logic [XLEN-1:0] alu_b_r,     alu_b_s;
    logic            mem_req_r,   mem_req_s;
    logic            mem_we_r,    mem_we_s;
    logic [1:0]      mem_size_r,  mem_size_s;
    logic [XLEN-1:0] mem_addr_r,  mem_addr_s;
    logic [XLEN-1:0] mem_wdata_r, mem_wdata_s;
    logic [XLEN-1:0] load_data_r, load_data_s;
    logic [7:0]      tmo_cnt_r,   tmo_cnt_s;
    logic            rf_we_r,     rf_we_s;
    logic [XLEN-1:0] rf_wdata_r,  rf_wdata_s;

    logic            mem_access_s;
    logic            tmo_hit_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] jalr_sum_s;

    assign mem_access_s = dec_load | (dec_store_size != 2'b00);
    assign tmo_hit_s    = (tmo_cnt_r == TMO_LAST);
    assign pc_plus4_s   = pc_r + PC_STEP;
    assign jalr_sum_s   = rv1 + immediate;

    // State register, plus the halted flag derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= S_START;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            halted_r <= halted_s;
        end
    end

    // Next-state logic; wait states leave on ack, bus error or timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_START: state_s = S_FETCH;
            S_FETCH: begin
                if (pc_r[1:0] != 2'b00) begin
                    state_s = S_MEM_ERROR;
                end else begin
                    state_s = S_WAIT_FETCH;
                end
            end
            S_WAIT_FETCH: begin
                if (mem_ack) begin
                    if (mem_err) begin
                        state_s = S_MEM_ERROR;
                    end else begin
                        state_s = S_DECODE;
                    end
                end else if (tmo_hit_s) begin
                    state_s = S_MEM_ERROR;
                end else begin
                    state_s = S_WAIT_FETCH;
                end
            end
            S_DECODE: state_s = S_EXECUTE;
            S_EXECUTE: begin
                if (dec_error) begin
                    state_s = S_DECODE_ERROR;
                end else begin
                    state_s = S_MEM_ACCESS;
                end
            end
            S_MEM_ACCESS: begin
                if (mem_access_s) begin
                    state_s = S_WAIT_MEM;
                end else begin
                    state_s = S_WRITEBACK;
                end
            end
            S_WAIT_MEM: begin
                if (mem_ack) begin
                    if (mem_err) begin
                        state_s = S_MEM_ERROR;
                    end else begin
                        state_s = S_WRITEBACK;
                    end
                end else if (tmo_hit_s) begin
                    state_s = S_MEM_ERROR;
                end else begin
                    state_s = S_WAIT_MEM;
                end
            end
            S_WRITEBACK:    state_s = S_FETCH;
            S_MEM_ERROR:    state_s = S_MEM_ERROR;
            S_DECODE_ERROR: state_s = S_DECODE_ERROR;
            S_FSM_ERROR:    state_s = S_FSM_ERROR;
            default:        state_s = S_FSM_ERROR;
        endcase
    end

    // Next values of the bus, datapath and writeback registers per state.
    always_comb begin
        pc_s        = pc_r;
        instr_s     = instr_r;
        alu_a_s     = alu_a_r;
        alu_b_s     = alu_b_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_size_s  = mem_size_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        load_data_s = load_data_r;
        tmo_cnt_s   = tmo_cnt_r;
        rf_we_s     = 1'b0;
        rf_wdata_s  = rf_wdata_r;
        case (state_r)
            S_FETCH: begin
                if (pc_r[1:0] == 2'b00) begin
                    mem_req_s  = 1'b1;
                    mem_addr_s = pc_r;
                    mem_we_s   = 1'b0;
                    mem_size_s = 2'b11;
                    tmo_cnt_s  = 8'd0;
                end else begin
                    mem_req_s  = 1'b0;
                end
            end
            S_WAIT_FETCH: begin
                if (mem_ack) begin
                    mem_req_s = 1'b0;
                    if (!mem_err) begin
                        instr_s = mem_rdata;
                    end else begin
                        instr_s = instr_r;
                    end
                end else if (tmo_hit_s) begin
                    mem_req_s = 1'b0;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 8'd1;
                end
            end
            S_EXECUTE: begin
                if (rs1_use_pc) begin
                    alu_a_s = pc_r;
                end else begin
                    alu_a_s = rv1;
                end
                if (rs2_use_imm) begin
                    alu_b_s = immediate;
                end else begin
                    alu_b_s = rv2;
                end
            end
            S_MEM_ACCESS: begin
                if (mem_access_s) begin
                    mem_req_s   = 1'b1;
                    mem_addr_s  = alu_out;
                    mem_wdata_s = rv2;
                    mem_we_s    = (dec_store_size != 2'b00);
                    tmo_cnt_s   = 8'd0;
                    if (dec_store_size != 2'b00) begin
                        mem_size_s = dec_store_size;
                    end else begin
                        mem_size_s = load_mem_size(dec_load_size);
                    end
                end else begin
                    mem_req_s = 1'b0;
                end
            end
            S_WAIT_MEM: begin
                if (mem_ack) begin
                    mem_req_s = 1'b0;
                    if (!mem_err) begin
                        load_data_s = load_extend(dec_load_size, mem_rdata);
                    end else begin
                        load_data_s = load_data_r;
                    end
                end else if (tmo_hit_s) begin
                    mem_req_s = 1'b0;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 8'd1;
                end
            end
            S_WRITEBACK: begin
                rf_we_s = dec_reg_write;
                if (dec_jump) begin
                    rf_wdata_s = pc_plus4_s;
                end else if (dec_load) begin
                    rf_wdata_s = load_data_r;
                end else begin
                    rf_wdata_s = alu_out;
                end
                if (dec_jump && dec_jal) begin
                    pc_s = pc_r + immediate;
                end else if (dec_jump) begin
                    pc_s = jalr_sum_s & LSB_CLEAR;
                end else if (dec_branch && branch_taken) begin
                    pc_s = pc_r + immediate;
                end else begin
                    pc_s = pc_plus4_s;
                end
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
        halted_s = (state_s == S_MEM_ERROR) || (state_s == S_DECODE_ERROR) ||
                   (state_s == S_FSM_ERROR);
    end

    // Datapath and bus registers; reset drops any outstanding request at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r        <= RESET_VECTOR;
            instr_r     <= {XLEN{1'b0}};
            alu_a_r     <= {XLEN{1'b0}};
            alu_b_r     <= {XLEN{1'b0}};
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_size_r  <= 2'b00;
            mem_addr_r  <= {XLEN{1'b0}};
            mem_wdata_r <= {XLEN{1'b0}};
            load_data_r <= {XLEN{1'b0}};
            tmo_cnt_r   <= 8'd0;
            rf_we_r     <= 1'b0;
            rf_wdata_r  <= {XLEN{1'b0}};
        end else begin
            pc_r        <= pc_s;
            instr_r     <= instr_s;
            alu_a_r     <= alu_a_s;
            alu_b_r     <= alu_b_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_size_r  <= mem_size_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            load_data_r <= load_data_s;
            tmo_cnt_r   <= tmo_cnt_s;
            rf_we_r     <= rf_we_s;
            rf_wdata_r  <= rf_wdata_s;
        end
    end

`ifdef INSTRET_EN
    logic [63:0] instret_r;

    // Retired-instruction count: one per WRITEBACK cycle, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_r <= 64'd0;
        end else if (state_r == S_WRITEBACK) begin
            instret_r <= instret_r + 64'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign instret = instret_r;
`endif

    assign state     = state_r;
    assign halted    = halted_r;
    assign pc        = pc_r;
    assign instr     = instr_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_size  = mem_size_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign rf_we     = rf_we_r;
    assign rf_wdata  = rf_wdata_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. The bench plays decoder,
// register file, adder ALU and memory; expectations come from instruction
// semantics (architectural PC / register-result model).

module tb_multicycle_controller;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_JAL = 3, K_JALR = 4, K_BR = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_ack, mem_err;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, instr;
    logic        dec_error, dec_load, dec_reg_write, dec_jump, dec_jal, dec_branch;
    logic [2:0]  dec_load_size;
    logic [1:0]  dec_store_size;
    logic        branch_taken, rs1_use_pc, rs2_use_imm;
    logic [31:0] immediate, rv1, rv2, alu_a, alu_b, alu_out, rf_wdata, pc;
    logic        rf_we, halted;
    logic [3:0]  state;
`ifdef INSTRET_EN
    logic [63:0] instret;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_pc;
    logic [63:0] m_retired;

    typedef struct {
        int          kind;
        logic [2:0]  f3;
        logic [1:0]  ssize;
        logic [31:0] rv1, rv2, imm, rdata, word;
        logic        rs1_pc, rs2_imm, reg_write, taken, err, merr, stray;
        int          fdelay, mdelay;
    } instr_t;

    always #5 clk = ~clk;

    // Environment ALU: plain adder.
    assign alu_out = alu_a + alu_b;

    multicycle_controller #(.XLEN(32), .RESET_VECTOR(32'h0), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
        .instr(instr), .dec_error(dec_error), .dec_load(dec_load),
        .dec_load_size(dec_load_size), .dec_store_size(dec_store_size),
        .dec_reg_write(dec_reg_write), .dec_jump(dec_jump), .dec_jal(dec_jal),
        .dec_branch(dec_branch), .branch_taken(branch_taken), .rs1_use_pc(rs1_use_pc),
        .rs2_use_imm(rs2_use_imm), .immediate(immediate), .rv1(rv1), .rv2(rv2),
        .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .rf_we(rf_we),
        .rf_wdata(rf_wdata), .pc(pc), .state(state), .halted(halted)
`ifdef INSTRET_EN
        , .instret(instret)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
        dec_error = 1'b0; dec_load = 1'b0; dec_load_size = 3'b000; dec_store_size = 2'b00;
        dec_reg_write = 1'b0; dec_jump = 1'b0; dec_jal = 1'b0; dec_branch = 1'b0;
        branch_taken = 1'b0; rs1_use_pc = 1'b0; rs2_use_imm = 1'b0;
        immediate = 32'h0; rv1 = 32'h0; rv2 = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) tick();
        rst = 1'b1;
        m_pc = 32'h0;
        m_retired = 64'd0;
    endtask

    // Architectural load result: pick the accessed width, then extend.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] v;
        case (f3)
            3'b000: begin v = raw % 32'd256;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'b001: begin v = raw % 32'd65536; if (v >= 32'd32768) v = v - 32'd65536; end
            3'b100: v = raw % 32'd256;
            3'b101: v = raw % 32'd65536;
            default: v = raw;
        endcase
        return v;
    endfunction

    function automatic instr_t blank();
        instr_t t;
        t.kind = K_ALU; t.f3 = 3'b000; t.ssize = 2'b00;
        t.rv1 = 32'h0; t.rv2 = 32'h0; t.imm = 32'h0; t.rdata = 32'h0; t.word = 32'h13;
        t.rs1_pc = 1'b0; t.rs2_imm = 1'b1; t.reg_write = 1'b1; t.taken = 1'b0;
        t.err = 1'b0; t.merr = 1'b0; t.stray = 1'b0; t.fdelay = 0; t.mdelay = 0;
        return t;
    endfunction

    // Drive one instruction through the controller and compare its effect.
    task automatic run_one(input instr_t t);
        int          n;
        logic [31:0] exp_a, exp_b, exp_addr, exp_rf, exp_pc, s;
        logic [1:0]  exp_size;
        logic        is_mem, is_st;
        n = 0;
        while (!(state === 4'h2 && mem_req === 1'b1) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL fetch_wait: state=%h mem_req=%b, required state=2 mem_req=1", state, mem_req);
            return;
        end
        checks++;
        if (mem_addr !== m_pc || mem_we !== 1'b0 || mem_size !== 2'b11) begin
            errors++;
            $display("FAIL fetch_bus: addr=%h we=%b size=%b, required addr=%h we=0 size=11",
                     mem_addr, mem_we, mem_size, m_pc);
        end
        repeat (t.fdelay) tick();
        checks++;
        if (state !== 4'h2 || mem_req !== 1'b1 || mem_addr !== m_pc) begin
            errors++;
            $display("FAIL fetch_hold: state=%h req=%b addr=%h, required 2/1/%h", state, mem_req, mem_addr, m_pc);
        end
        dec_error = t.err; dec_load = (t.kind == K_LOAD); dec_load_size = t.f3;
        dec_store_size = (t.kind == K_STORE) ? t.ssize : 2'b00;
        dec_reg_write = t.reg_write; dec_jump = (t.kind == K_JAL || t.kind == K_JALR);
        dec_jal = (t.kind == K_JAL); dec_branch = (t.kind == K_BR); branch_taken = t.taken;
        rs1_use_pc = t.rs1_pc; rs2_use_imm = t.rs2_imm; immediate = t.imm; rv1 = t.rv1; rv2 = t.rv2;
        mem_ack = 1'b1; mem_err = 1'b0; mem_rdata = t.word;
        tick();
        mem_ack = t.stray; mem_err = t.stray; mem_rdata = $urandom();
        checks++;
        if (state !== 4'h3 || instr !== t.word || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done: state=%h instr=%h req=%b, required 3/%h/0", state, instr, mem_req, t.word);
        end
        tick();
        mem_ack = 1'b0; mem_err = 1'b0;
        checks++;
        if (state !== 4'h4) begin
            errors++;
            $display("FAIL execute_state: state=%h, required 4", state);
        end
        tick();
        if (t.err) begin
            checks++;
            if (state !== 4'hE || halted !== 1'b1 || pc !== m_pc || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL decode_error: state=%h halted=%b pc=%h req=%b, required E/1/%h/0",
                         state, halted, pc, mem_req, m_pc);
            end
`ifdef INSTRET_EN
            checks++;
            if (instret !== m_retired) begin
                errors++;
                $display("FAIL instret_on_error: instret=%0d, required %0d", instret, m_retired);
            end
`endif
            repeat (3) tick();
            checks++;
            if (state !== 4'hE || rf_we !== 1'b0 || mem_req !== 1'b0 || pc !== m_pc) begin
                errors++;
                $display("FAIL decode_error_sticky: state=%h rf_we=%b req=%b pc=%h, required E/0/0/%h",
                         state, rf_we, mem_req, pc, m_pc);
            end
            return;
        end
        exp_a = t.rs1_pc ? m_pc : t.rv1;
        exp_b = t.rs2_imm ? t.imm : t.rv2;
        checks++;
        if (state !== 4'h5 || alu_a !== exp_a || alu_b !== exp_b) begin
            errors++;
            $display("FAIL operands: state=%h a=%h b=%h, required 5/%h/%h", state, alu_a, alu_b, exp_a, exp_b);
        end
        is_st  = (t.kind == K_STORE);
        is_mem = (t.kind == K_LOAD) || is_st;
        tick();
        if (is_mem) begin
            exp_addr = exp_a + exp_b;
            if (is_st) exp_size = t.ssize;
            else if (t.f3 == 3'b000 || t.f3 == 3'b100) exp_size = 2'b01;
            else if (t.f3 == 3'b001 || t.f3 == 3'b101) exp_size = 2'b10;
            else exp_size = 2'b11;
            checks++;
            if (state !== 4'h6 || mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== is_st ||
                mem_size !== exp_size || (is_st && mem_wdata !== t.rv2)) begin
                errors++;
                $display("FAIL data_bus: state=%h req=%b addr=%h we=%b size=%b wdata=%h, required 6/1/%h/%b/%b/%h",
                         state, mem_req, mem_addr, mem_we, mem_size, mem_wdata, exp_addr, is_st, exp_size, t.rv2);
            end
            repeat (t.mdelay) tick();
            checks++;
            if (state !== 4'h6 || mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== is_st ||
                mem_size !== exp_size || (is_st && mem_wdata !== t.rv2) || rf_we !== 1'b0) begin
                errors++;
                $display("FAIL data_hold: state=%h req=%b addr=%h we=%b size=%b rf_we=%b, required 6/1/%h/%b/%b/0",
                         state, mem_req, mem_addr, mem_we, mem_size, rf_we, exp_addr, is_st, exp_size);
            end
            mem_ack = 1'b1; mem_err = t.merr; mem_rdata = t.rdata;
            tick();
            mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = $urandom();
            if (t.merr) begin
                checks++;
                if (state !== 4'hD || halted !== 1'b1 || mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL mem_error: state=%h halted=%b req=%b, required D/1/0", state, halted, mem_req);
                end
                repeat (3) tick();
                checks++;
                if (state !== 4'hD || rf_we !== 1'b0 || mem_req !== 1'b0 || pc !== m_pc) begin
                    errors++;
                    $display("FAIL mem_error_sticky: state=%h rf_we=%b req=%b pc=%h, required D/0/0/%h",
                             state, rf_we, mem_req, pc, m_pc);
                end
                return;
            end
        end
        checks++;
        if (state !== 4'h7 || mem_req !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL writeback_state: state=%h req=%b rf_we=%b, required 7/0/0", state, mem_req, rf_we);
        end
        if (t.kind == K_JAL || t.kind == K_JALR) exp_rf = m_pc + 32'd4;
        else if (t.kind == K_LOAD) exp_rf = model_load(t.f3, t.rdata);
        else exp_rf = exp_a + exp_b;
        if (t.kind == K_JAL) exp_pc = m_pc + t.imm;
        else if (t.kind == K_JALR) begin
            s = t.rv1 + t.imm;
            exp_pc = (s % 32'd2 == 32'd1) ? s - 32'd1 : s;
        end
        else if (t.kind == K_BR && t.taken) exp_pc = m_pc + t.imm;
        else exp_pc = m_pc + 32'd4;
        tick();
        m_retired = m_retired + 64'd1;
        checks++;
        if (state !== 4'h1 || pc !== exp_pc || rf_we !== t.reg_write || (t.reg_write && rf_wdata !== exp_rf)) begin
            errors++;
            $display("FAIL retire: state=%h pc=%h rf_we=%b rf_wdata=%h, required 1/%h/%b/%h",
                     state, pc, rf_we, rf_wdata, exp_pc, t.reg_write, exp_rf);
        end
`ifdef INSTRET_EN
        checks++;
        if (instret !== m_retired) begin
            errors++;
            $display("FAIL instret: instret=%0d, required %0d", instret, m_retired);
        end
`endif
        m_pc = exp_pc;
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL rf_we_pulse: rf_we=%b one cycle later, required 0", rf_we);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) tick();
        checks++;
        if (state !== 4'h0 || pc !== 32'h0 || mem_req !== 1'b0 || halted !== 1'b0 || rf_we !== 1'b0 ||
            instr !== 32'h0 || alu_a !== 32'h0 || alu_b !== 32'h0 || mem_addr !== 32'h0 || rf_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: state=%h pc=%h req=%b halted=%b rf_we=%b instr=%h, required all 0",
                     state, pc, mem_req, halted, rf_we, instr);
        end
        rst = 1'b1;
        m_pc = 32'h0;
        m_retired = 64'd0;
        tick();
        checks++;
        if (state !== 4'h1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch: state=%h req=%b, required 1/0", state, mem_req);
        end
    endtask

    task automatic test_addi();
        instr_t t;
        t = blank();
        t.word = 32'h00500093; t.imm = 32'd5; t.fdelay = 1;
        run_one(t);
        checks++;
        if (rf_wdata !== 32'd5 || pc !== 32'd4) begin
            errors++;
            $display("FAIL addi: rf_wdata=%h pc=%h, required 5/4", rf_wdata, pc);
        end
    endtask

    task automatic test_loads();
        instr_t t;
        t = blank();
        t.kind = K_LOAD; t.f3 = 3'b000; t.rv1 = 32'h200; t.rdata = 32'h000000F0; t.word = 32'h20000083;
        run_one(t);
        checks++;
        if (rf_wdata !== 32'hFFFFFFF0) begin
            errors++;
            $display("FAIL lb: rf_wdata=%h, required FFFFFFF0", rf_wdata);
        end
        t.f3 = 3'b100; t.word = 32'h20004083; t.mdelay = 2;
        run_one(t);
        checks++;
        if (rf_wdata !== 32'h000000F0) begin
            errors++;
            $display("FAIL lbu: rf_wdata=%h, required 000000F0", rf_wdata);
        end
    endtask

    task automatic test_store();
        instr_t t;
        t = blank();
        t.kind = K_STORE; t.ssize = 2'b11; t.rv1 = 32'h100; t.rv2 = 32'hDEADBEEF;
        t.reg_write = 1'b0; t.mdelay = 5; t.word = 32'h00202023;
        run_one(t);
    endtask

    task automatic test_random(input int count);
        instr_t t;
        int     k;
        for (int i = 0; i < count; i++) begin
            t = blank();
            t.kind = $urandom_range(0, 5);
            t.word = $urandom(); t.rv1 = $urandom(); t.rv2 = $urandom(); t.imm = $urandom();
            t.rdata = $urandom(); t.fdelay = $urandom_range(0, 4); t.mdelay = $urandom_range(0, 4);
            t.stray = ($urandom_range(0, 3) == 0);
            k = $urandom_range(0, 32);
            case (t.kind)
                K_ALU: begin
                    t.rs1_pc = $urandom_range(0, 1); t.rs2_imm = $urandom_range(0, 1);
                    t.reg_write = $urandom_range(0, 1);
                end
                K_LOAD: begin
                    k = $urandom_range(0, 4);
                    t.f3 = (k == 0) ? 3'b000 : (k == 1) ? 3'b001 : (k == 2) ? 3'b010 :
                           (k == 3) ? 3'b100 : 3'b101;
                end
                K_STORE: begin
                    t.ssize = 2'($urandom_range(1, 3)); t.reg_write = 1'b0;
                end
                K_JAL: begin
                    t.imm = 32'((k - 16) * 4); t.rs1_pc = 1'b1;
                end
                K_JALR: begin
                    t.rv1 = ($urandom() & 32'hFFFFFFFC) | 32'($urandom_range(0, 1));
                    t.imm = 32'((k - 16) * 4);
                end
                default: begin
                    t.imm = 32'((k - 16) * 4); t.taken = $urandom_range(0, 1);
                    t.reg_write = 1'b0; t.rs2_imm = 1'b0;
                end
            endcase
            run_one(t);
        end
    endtask

    task automatic test_jalr_misalign();
        instr_t t;
        logic   ok;
        t = blank();
        t.kind = K_JAL; t.imm = 32'h20 - m_pc; t.reg_write = 1'b0;
        run_one(t);
        t = blank();
        t.kind = K_JALR; t.rv1 = 32'h41; t.imm = 32'h0;
        run_one(t);
        checks++;
        if (rf_wdata !== 32'h24 || pc !== 32'h40) begin
            errors++;
            $display("FAIL jalr: rf_wdata=%h pc=%h, required 24/40", rf_wdata, pc);
        end
        t = blank();
        t.kind = K_JAL; t.imm = 32'h2; t.reg_write = 1'b0;
        run_one(t);
        checks++;
        if (state !== 4'hD || halted !== 1'b1 || mem_req !== 1'b0 || pc !== 32'h42) begin
            errors++;
            $display("FAIL misaligned_fetch: state=%h halted=%b req=%b pc=%h, required D/1/0/42",
                     state, halted, mem_req, pc);
        end
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_req !== 1'b0 || state !== 4'hD || rf_we !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_sticky: state=%h req=%b, required D/0 throughout", state, mem_req);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        n = 0;
        while (state !== 4'h2 && n < 10) begin
            tick();
            n++;
        end
        n = 0;
        while (state === 4'h2 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 15 || state !== 4'hD || halted !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_timeout: cycles=%0d state=%h halted=%b req=%b, required 15/D/1/0",
                     n, state, halted, mem_req);
        end
    endtask

    task automatic test_reset_mid_wait();
        instr_t t;
        int     n;
        do_reset();
        t = blank();
        t.imm = 32'd7;
        run_one(t);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || pc !== 32'h0 || state !== 4'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: req=%b pc=%h state=%h halted=%b, required 0/0/0/0",
                     mem_req, pc, state, halted);
        end
        mem_ack = 1'b1; mem_err = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0; mem_err = 1'b0;
        checks++;
        if (state !== 4'h2 || mem_req !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL stale_ack: state=%h req=%b halted=%b, required 2/1/0", state, mem_req, halted);
        end
        m_pc = 32'h0;
        m_retired = 64'd0;
        n = $urandom_range(0, 3);
        repeat (n) tick();
        t = blank();
        t.imm = 32'd9;
        run_one(t);
    endtask

    task automatic test_decode_error();
        instr_t t;
        do_reset();
        t = blank();
        t.imm = 32'd3;
        run_one(t);
        t = blank();
        t.err = 1'b1;
        run_one(t);
    endtask

    task automatic test_mem_err();
        instr_t t;
        do_reset();
        t = blank();
        t.kind = K_LOAD; t.f3 = 3'b010; t.rv1 = 32'h300; t.merr = 1'b1; t.mdelay = 1;
        run_one(t);
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        m_pc = 32'h0;
        m_retired = 64'd0;
        test_reset();
        test_addi();
        test_loads();
        test_store();
        test_random(30);
        test_jalr_misalign();
        test_timeout();
        test_reset_mid_wait();
        test_decode_error();
        test_mem_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
